// File: rtl/rob_ctrl.sv
// rob_ctrl: in-order tag allocator and by-tag writer/drainer for the rob_512x256 RAM; ports alloc_*, rsp_*, out_*, ram_*, occupancy, err; define ROB_CTRL_ERR_CHK_EN to check responses
module rob_ctrl #(
  parameter int DATA_W = 512,
  parameter int TAG_W = 8,
  parameter int OFIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              rsp_valid,
  input  logic [TAG_W-1:0]  rsp_tag,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W:0]    occupancy,
  output logic              err,
  output logic              ram_wr_en,
  output logic [TAG_W-1:0]  ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [TAG_W-1:0]  ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
);
  localparam int DEPTH = 1 << TAG_W;
  localparam int PW = $clog2(OFIFO_D);
  logic [TAG_W-1:0]  head, tail;
  logic [TAG_W:0]    count;
  logic [DEPTH-1:0]  done, done_nxt;
  logic [1:0]        rd_vld;
  logic [DATA_W-1:0] mem [OFIFO_D];
  logic [PW-1:0]     wp, rp;
  logic [PW:0]       fcnt;
  logic [PW+1:0]     pending;
  logic              issue, fempty, push_fifo, pop_fifo, rsp_ok;
  assign alloc_gnt = alloc_req & (count != (TAG_W+1)'(DEPTH)) & ~rst;
  assign alloc_tag = tail;
  assign occupancy = count;
  assign ram_rd_addr = head;
  assign pending = {1'b0, fcnt} + (PW+2)'(rd_vld[0]) + (PW+2)'(rd_vld[1]);
  assign issue = (count != '0) & done[head] & (pending < (PW+2)'(OFIFO_D));
  assign fempty = fcnt == '0;
  assign out_valid = ~fempty | rd_vld[1];
  assign out_data = ~fempty ? mem[rp] : rd_vld[1] ? ram_rd_data : '0;
  assign pop_fifo = ~fempty & out_ready;
  // a returning read goes straight to the consumer when nothing is queued ahead of it
  assign push_fifo = rd_vld[1] & ~(fempty & out_ready);
`ifdef ROB_CTRL_ERR_CHK_EN
  logic [TAG_W-1:0] rsp_off;
  logic             err_q;
  assign rsp_off = rsp_tag - head;
  assign rsp_ok = ({1'b0, rsp_off} < count) & ~done[rsp_tag];
  assign err = err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else if (rsp_valid & ~rsp_ok) err_q <= 1'b1;
`else
  assign rsp_ok = 1'b1;
  assign err = 1'b0;
`endif
  always_comb begin
    done_nxt = done;
    if (issue) done_nxt[head] = 1'b0;
    if (rsp_valid & rsp_ok) done_nxt[rsp_tag] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      done <= '0;
      rd_vld <= '0;
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
      ram_wr_en <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      tail <= tail + TAG_W'(alloc_gnt);
      head <= head + TAG_W'(issue);
      count <= count + (TAG_W+1)'(alloc_gnt) - (TAG_W+1)'(issue);
      done <= done_nxt;
      rd_vld <= {rd_vld[0], issue};
      wp <= wp + PW'(push_fifo);
      rp <= rp + PW'(pop_fifo);
      fcnt <= fcnt + (PW+1)'(push_fifo) - (PW+1)'(pop_fifo);
      ram_wr_en <= rsp_valid & rsp_ok;
      ram_wr_addr <= rsp_tag;
      ram_wr_data <= rsp_data;
    end
  always_ff @(posedge clk)
    if (push_fifo) mem[wp] <= ram_rd_data;
endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: randomized self-checking bench for rob_ctrl with a RAM model and in-order scoreboard
module tb_rob_ctrl;
  logic         clk = 0, rst = 0;
  logic         alloc_req = 0, alloc_gnt;
  logic [7:0]   alloc_tag;
  logic         rsp_valid = 0;
  logic [7:0]   rsp_tag = 0;
  logic [511:0] rsp_data = 0;
  logic         out_valid, out_ready = 1;
  logic [511:0] out_data;
  logic [8:0]   occupancy;
  logic         err, ram_wr_en;
  logic [7:0]   ram_wr_addr, ram_rd_addr;
  logic [511:0] ram_wr_data, ram_rd_data;
  logic [511:0] ram [256];
  logic [7:0]   ra_q;
  logic [511:0] rq;
  logic [7:0]   gq[$];
  logic [511:0] bq[$];
  int errors = 0, checks = 0;

  rob_ctrl dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .err(err),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    ra_q <= ram_rd_addr;
    rq <= ram[ra_q];
  end
  assign ram_rd_data = rq;

  always @(negedge clk)
    if (!rst) begin
      if (alloc_gnt) gq.push_back(alloc_tag);
      if (out_valid && out_ready) bq.push_back(out_data);
    end

  function automatic logic [511:0] rand_data();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst = 1;
    alloc_req = 0;
    rsp_valid = 0;
    out_ready = 1;
    tick();
    tick();
    rst = 0;
    gq.delete();
    bq.delete();
  endtask

  task automatic test_reset();
    #1 rst = 1;
    alloc_req = 1;
    #2;
    checks++;
    if (alloc_gnt !== 0 || alloc_tag !== 0 || out_valid !== 0 || out_data !== 0 || occupancy !== 0) begin
      errors++;
      $display("FAIL reset_out: gnt=%0b tag=%0d ov=%0b od=%0h occ=%0d required 0", alloc_gnt, alloc_tag, out_valid, out_data, occupancy);
    end
    checks++;
    if (err !== 0 || ram_wr_en !== 0 || ram_wr_addr !== 0 || ram_wr_data !== 0 || ram_rd_addr !== 0) begin
      errors++;
      $display("FAIL reset_ram: err=%0b we=%0b wa=%0d wd=%0h ra=%0d required 0", err, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr);
    end
    apply_reset();
  endtask

  task automatic test_single();
    logic [511:0] a5;
    a5 = {64{8'hA5}};
    apply_reset();
    alloc_req = 1;
    #3;
    checks++;
    if (alloc_gnt !== 1 || alloc_tag !== 0) begin
      errors++;
      $display("FAIL single_gnt: gnt=%0b tag=%0d required 1/0", alloc_gnt, alloc_tag);
    end
    tick();
    alloc_req = 0;
    rsp_valid = 1;
    rsp_tag = 0;
    rsp_data = a5;
    #3;
    checks++;
    if (occupancy !== 1) begin
      errors++;
      $display("FAIL single_occ1: occ=%0d required 1", occupancy);
    end
    tick();
    rsp_valid = 0;
    #3;
    checks++;
    if (ram_wr_en !== 1 || ram_wr_addr !== 0 || ram_wr_data !== a5 || out_valid !== 0) begin
      errors++;
      $display("FAIL single_wr: we=%0b wa=%0d ov=%0b required 1/0/0", ram_wr_en, ram_wr_addr, out_valid);
    end
    tick();
    #3;
    checks++;
    if (out_valid !== 0) begin
      errors++;
      $display("FAIL single_early: ov=%0b required 0 at rsp+2", out_valid);
    end
    tick();
    #3;
    checks++;
    if (out_valid !== 1 || out_data !== a5 || occupancy !== 0) begin
      errors++;
      $display("FAIL single_out: ov=%0b od=%0h occ=%0d required 1/a5../0", out_valid, out_data, occupancy);
    end
    tick();
    #3;
    checks++;
    if (out_valid !== 0 || bq.size() != 1) begin
      errors++;
      $display("FAIL single_once: ov=%0b beats=%0d required 0/1", out_valid, bq.size());
    end
  endtask

  task automatic test_reverse();
    logic [511:0] d [4];
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      alloc_req = 1;
      #3;
      if (alloc_gnt !== 1 || alloc_tag !== 8'(i)) bad++;
      tick();
    end
    alloc_req = 0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rev_tags: bad=%0d required 0", bad);
    end
    for (int i = 3; i >= 1; i--) begin
      d[i] = rand_data();
      rsp_valid = 1;
      rsp_tag = 8'(i);
      rsp_data = d[i];
      tick();
    end
    rsp_valid = 0;
    idle(6);
    checks++;
    if (bq.size() != 0 || occupancy !== 4) begin
      errors++;
      $display("FAIL rev_hold: beats=%0d occ=%0d required 0/4", bq.size(), occupancy);
    end
    d[0] = rand_data();
    rsp_valid = 1;
    rsp_tag = 0;
    rsp_data = d[0];
    tick();
    rsp_valid = 0;
    idle(8);
    checks++;
    if (bq.size() != 4) begin
      errors++;
      $display("FAIL rev_count: beats=%0d required 4", bq.size());
    end else
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bq[i] !== d[i]) begin
          errors++;
          $display("FAIL rev_data%0d: got %0h required %0h", i, bq[i], d[i]);
        end
      end
  endtask

  task automatic test_full();
    int bad;
    apply_reset();
    bad = 0;
    alloc_req = 1;
    for (int i = 0; i < 256; i++) begin
      #3;
      if (alloc_gnt !== 1 || alloc_tag !== 8'(i)) bad++;
      tick();
    end
    #3;
    checks++;
    if (bad != 0 || occupancy !== 256 || alloc_gnt !== 0) begin
      errors++;
      $display("FAIL full: bad=%0d occ=%0d gnt=%0b required 0/256/0", bad, occupancy, alloc_gnt);
    end
    rsp_valid = 1;
    rsp_tag = 0;
    rsp_data = rand_data();
    tick();
    rsp_valid = 0;
    #3;
    checks++;
    if (alloc_gnt !== 0) begin
      errors++;
      $display("FAIL full_issue_cycle: gnt=%0b required 0", alloc_gnt);
    end
    tick();
    #3;
    checks++;
    if (alloc_gnt !== 1 || alloc_tag !== 0 || occupancy !== 255) begin
      errors++;
      $display("FAIL full_wrap: gnt=%0b tag=%0d occ=%0d required 1/0/255", alloc_gnt, alloc_tag, occupancy);
    end
    tick();
    alloc_req = 0;
  endtask

  task automatic test_backpressure();
    logic [511:0] d [8];
    int perm [8];
    int j, t;
    apply_reset();
    out_ready = 0;
    alloc_req = 1;
    idle(8);
    alloc_req = 0;
    for (int i = 0; i < 8; i++) perm[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 8; i++) begin
      d[perm[i]] = rand_data();
      rsp_valid = 1;
      rsp_tag = 8'(perm[i]);
      rsp_data = d[perm[i]];
      tick();
    end
    rsp_valid = 0;
    idle(20);
    #3;
    checks++;
    if (bq.size() != 0 || occupancy !== 4 || out_valid !== 1 || out_data !== d[0]) begin
      errors++;
      $display("FAIL bp_hold: beats=%0d occ=%0d ov=%0b required 0/4/1 and head data", bq.size(), occupancy, out_valid);
    end
    tick();
    out_ready = 1;
    idle(8);
    checks++;
    if (bq.size() != 8) begin
      errors++;
      $display("FAIL bp_b2b: beats=%0d in 8 cycles required 8", bq.size());
    end else
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (bq[i] !== d[i]) begin
          errors++;
          $display("FAIL bp_data%0d: got %0h required %0h", i, bq[i], d[i]);
        end
      end
    #3;
    checks++;
    if (out_valid !== 0 || occupancy !== 0) begin
      errors++;
      $display("FAIL bp_empty: ov=%0b occ=%0d required 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_err();
`ifdef ROB_CTRL_ERR_CHK_EN
    logic [511:0] d0, d1;
    apply_reset();
    rsp_valid = 1;
    rsp_tag = 7;
    rsp_data = rand_data();
    tick();
    rsp_valid = 0;
    #3;
    checks++;
    if (err !== 1 || ram_wr_en !== 0) begin
      errors++;
      $display("FAIL err_unalloc: err=%0b we=%0b required 1/0", err, ram_wr_en);
    end
    apply_reset();
    alloc_req = 1;
    idle(2);
    alloc_req = 0;
    d0 = rand_data();
    d1 = rand_data();
    rsp_valid = 1;
    rsp_tag = 1;
    rsp_data = d1;
    tick();
    rsp_tag = 1;
    rsp_data = ~d1;
    #3;
    checks++;
    if (err !== 0 || ram_wr_en !== 1) begin
      errors++;
      $display("FAIL err_good: err=%0b we=%0b required 0/1", err, ram_wr_en);
    end
    tick();
    rsp_tag = 0;
    rsp_data = d0;
    #3;
    checks++;
    if (err !== 1 || ram_wr_en !== 0) begin
      errors++;
      $display("FAIL err_dup: err=%0b we=%0b required 1/0", err, ram_wr_en);
    end
    tick();
    rsp_valid = 0;
    idle(8);
    checks++;
    if (bq.size() != 2 || bq[0] !== d0 || bq[1] !== d1) begin
      errors++;
      $display("FAIL err_keep: beats=%0d required 2 with original data", bq.size());
    end
`else
    apply_reset();
    rsp_valid = 1;
    rsp_tag = 7;
    rsp_data = rand_data();
    tick();
    rsp_valid = 0;
    #3;
    checks++;
    if (err !== 0 || ram_wr_en !== 1) begin
      errors++;
      $display("FAIL err_off: err=%0b we=%0b required 0/1", err, ram_wr_en);
    end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 0;
    alloc_req = 1;
    idle(4);
    alloc_req = 0;
    for (int i = 0; i < 4; i++) begin
      rsp_valid = 1;
      rsp_tag = 8'(i);
      rsp_data = rand_data();
      tick();
    end
    rsp_valid = 0;
    tick();
    alloc_req = 1;
    #2 rst = 1;
    #1;
    checks++;
    if (alloc_gnt !== 0 || alloc_tag !== 0 || out_valid !== 0 || out_data !== 0 || occupancy !== 0 ||
        err !== 0 || ram_wr_en !== 0 || ram_wr_addr !== 0 || ram_wr_data !== 0 || ram_rd_addr !== 0) begin
      errors++;
      $display("FAIL mid_reset: gnt=%0b tag=%0d ov=%0b occ=%0d we=%0b ra=%0d required all 0", alloc_gnt, alloc_tag, out_valid, occupancy, ram_wr_en, ram_rd_addr);
    end
    tick();
    tick();
    rst = 0;
    out_ready = 1;
    gq.delete();
    bq.delete();
    #3;
    checks++;
    if (alloc_gnt !== 1 || alloc_tag !== 0) begin
      errors++;
      $display("FAIL mid_first_tag: gnt=%0b tag=%0d required 1/0", alloc_gnt, alloc_tag);
    end
    tick();
    alloc_req = 0;
    idle(6);
    checks++;
    if (bq.size() != 0 || out_valid !== 0 || occupancy !== 1) begin
      errors++;
      $display("FAIL mid_stale: beats=%0d ov=%0b occ=%0d required 0/0/1", bq.size(), out_valid, occupancy);
    end
  endtask

  task automatic test_random();
    logic [511:0] data_k [int];
    int pending[$];
    int k_next, n_out, tagbad, outbad, idx, k;
    logic [7:0] tg;
    logic [511:0] b;
    apply_reset();
    k_next = 0;
    n_out = 0;
    tagbad = 0;
    outbad = 0;
    for (int c = 0; c < 4500; c++) begin
      if (c < 1500) begin
        alloc_req = $urandom_range(0, 1) == 1;
        out_ready = $urandom_range(0, 3) != 0;
      end else begin
        alloc_req = 0;
        out_ready = 1;
      end
      if (pending.size() > 0 && (c >= 1500 || $urandom_range(0, 3) != 0)) begin
        idx = $urandom_range(0, pending.size() - 1);
        k = pending[idx];
        pending.delete(idx);
        data_k[k] = rand_data();
        rsp_valid = 1;
        rsp_tag = 8'(k);
        rsp_data = data_k[k];
      end else
        rsp_valid = 0;
      tick();
      while (gq.size() > 0) begin
        tg = gq.pop_front();
        if (tg !== 8'(k_next)) tagbad++;
        pending.push_back(k_next);
        k_next++;
      end
      while (bq.size() > 0) begin
        b = bq.pop_front();
        if (!data_k.exists(n_out) || b !== data_k[n_out]) outbad++;
        n_out++;
      end
      if (c >= 1500 && pending.size() == 0 && n_out == k_next) break;
    end
    rsp_valid = 0;
    #3;
    checks++;
    if (tagbad != 0) begin
      errors++;
      $display("FAIL rand_tags: bad=%0d required 0", tagbad);
    end
    checks++;
    if (outbad != 0 || n_out != k_next || k_next == 0) begin
      errors++;
      $display("FAIL rand_order: bad=%0d beats=%0d required 0/%0d", outbad, n_out, k_next);
    end
    checks++;
    if (occupancy !== 0 || out_valid !== 0) begin
      errors++;
      $display("FAIL rand_drained: occ=%0d ov=%0b required 0/0", occupancy, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reverse();
    test_full();
    test_backpressure();
    test_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
